// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file, combinational reads, synchronous write.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding from wd to the read ports.
module regfile #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] wa,
   input  logic              we,
   input  logic [DATA_W-1:0] wd,
   input  logic              clk,
   input  logic              rst
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Reset wins over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = mem[ra1];
      rd2 = mem[ra2];
`ifdef REGFILE_BYPASS_EN
      // Forward the pending write so a same-cycle reader sees the new value.
      if (we && !rst && (ra1 == wa)) begin
         rd1 = wd;
      end
      if (we && !rst && (ra2 == wa)) begin
         rd2 = wd;
      end
`else
`endif
   end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile: directed steps plus randomized traffic.
`timescale 1ns/1ps
module tb_regfile;

   logic       clk;
   logic       rst;
   logic [7:0] rd1;
   logic [7:0] rd2;
   logic [2:0] ra1;
   logic [2:0] ra2;
   logic [2:0] wa;
   logic       we;
   logic [7:0] wd;

   int vectors;
   int miscompares;

   logic [7:0] model [8];

   regfile #(.DATA_W(8), .ADDR_W(3)) dut (
      .rd1(rd1),
      .rd2(rd2),
      .ra1(ra1),
      .ra2(ra2),
      .wa (wa),
      .we (we),
      .wd (wd),
      .clk(clk),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference storage: what each register should hold after every edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) model[k] <= 8'h00;
      end else if (we) begin
         model[wa] <= wd;
      end
   end

   function automatic logic [7:0] exp_rd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
      if (we && !rst && a == wa) return wd;
`endif
      return model[a];
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_pair(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                            input logic [7:0] e1, input logic [7:0] e2);
      @(negedge clk);
      ra1 = a1;
      ra2 = a2;
      #1;
      chk({tag, "_rd1"}, rd1, e1);
      chk({tag, "_rd2"}, rd2, e2);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      we = 1'b0;
      wa = '0;
      wd = '0;
      ra1 = '0;
      ra2 = '0;

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++)
         read_pair("reset", 3'(i), 3'(7 - i), 8'h00, 8'h00);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         we = 1'b1;
         wa = 3'(i);
         wd = 8'h80 + 8'(i);
      end
      @(negedge clk);
      we = 1'b0;
      for (int i = 0; i < 8; i++)
         read_pair("fill", 3'(i), 3'(7 - i), 8'h80 + 8'(i), 8'h87 - 8'(i));

      @(negedge clk);
      we = 1'b0;
      wa = 3'd3;
      wd = 8'hFF;
      read_pair("wr_disable", 3'd3, 3'd3, 8'h83, 8'h83);

      read_pair("same_addr", 3'd5, 3'd5, 8'h85, 8'h85);
      @(negedge clk);
      we = 1'b1;
      wa = 3'd5;
      wd = 8'h55;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("pre_edge_rd1", rd1, 8'h55);
`else
      chk("pre_edge_rd1", rd1, 8'h85);
`endif
      @(posedge clk);
      #1;
      chk("post_edge_rd1", rd1, 8'h55);
      chk("post_edge_rd2", rd2, 8'h55);
      @(negedge clk);
      we = 1'b0;

      @(negedge clk);
      rst = 1'b1;
      we = 1'b1;
      wa = 3'd1;
      wd = 8'hAA;
      ra1 = 3'd1;
      #1;
      chk("rst_no_fwd", rd1, 8'h81);
      @(negedge clk);
      rst = 1'b0;
      we = 1'b0;
      for (int i = 0; i < 8; i++)
         read_pair("rst_prio", 3'(i), 3'(7 - i), 8'h00, 8'h00);

      @(negedge clk);
      we = 1'b1;
      wa = 3'd7;
      wd = 8'h12;
      @(negedge clk);
      wd = 8'h34;
      @(negedge clk);
      we = 1'b0;
      read_pair("overwrite", 3'd0, 3'd7, 8'h00, 8'h34);

      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 40) == 0);
         we  = $urandom_range(0, 1) == 1;
         wa  = 3'($urandom_range(0, 7));
         wd  = 8'($urandom);
         ra1 = 3'($urandom_range(0, 7));
         ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 3'($urandom_range(0, 7));
         #1;
         chk("rand_rd1", rd1, exp_rd(ra1));
         chk("rand_rd2", rd2, exp_rd(ra2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Multi-ported register file: 2 asynchronous (combinational) read ports and 1 synchronous write port.
- Default geometry is 8 registers x 8 bits.
- Sits in the CPU datapath, feeding ALU operands (rd1/rd2) and accepting writeback results (wd).
- No hardwired-zero register; all entries are writable storage.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, width of the address ports; DEPTH = 2**ADDR_W registers (8 by default).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset; clears all registers.
- rd1  output  DATA_W  read data port 1 = reg[ra1].
- rd2  output  DATA_W  read data port 2 = reg[ra2].
- ra1  input  ADDR_W  read address 1.
- ra2  input  ADDR_W  read address 2.
- wa  input  ADDR_W  write address.
- we  input  1  write enable, active high.
- wd  input  DATA_W  write data.
- Positional port order (fixed): rd1, rd2, ra1, ra2, wa, we, wd, clk, rst.
- Reset is synchronous, active-high, on the single clock clk.

Behaviour:
- Storage: DEPTH x DATA_W flip-flop array, reg[0..DEPTH-1].
- Reset:
  - At posedge clk with rst=1, every reg[i] <= 0.
  - rst has priority over we; a write presented in the same cycle is discarded.
  - Reset asserted mid-sequence clears everything, including registers written earlier.
  - Before the first reset or write, contents are undefined; benches must reset first.
  - rd1/rd2 read 0 for every address after reset.
- Write: at posedge clk with rst=0 and we=1, reg[wa] <= wd. With we=0, no register changes.
- Read:
  - rd1 = reg[ra1], rd2 = reg[ra2], purely combinational, no clock latency.
  - Outputs change immediately when the address changes.
  - Outputs reflect a newly written value immediately after the write edge.
- Simultaneous events:
  - ra1 == ra2 is legal; both ports return the same value.
  - Read address equal to wa while we=1 (base build): the read returns the old value until the clock edge, then the new value.
- All address values 0..DEPTH-1 are valid; there are no out-of-range addresses.
- No internal pipelining; one write per cycle max.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If we=1, rst=0 and ra1==wa, rd1 = wd combinationally in the same cycle; likewise rd2 when ra2==wa. During rst=1 there is no forwarding.
- Undefined: reads return the stored value only, as in the base build.

Test Plan:
- Reset: rst=1 for 1 posedge -> all reads (ra1=0..7, ra2=7..0) return 0x00.
- Fill: we=1, for i=0..7 set wa=i and wd=0x80+i, one posedge each; then we=0; sweep ra1=i, ra2=7-i -> rd1=0x80+i, rd2=0x87-i (e.g. i=2: rd1=0x82, rd2=0x85).
- Write disable: we=0, wa=3, wd=0xFF, one posedge -> reg3 still reads 0x83 on both ports.
- Same-address read: ra1=ra2=5 -> rd1=rd2=0x85. Then write wa=5, wd=0x55 -> base build: rd1 reads 0x85 before the edge and 0x55 after it; with REGFILE_BYPASS_EN: rd1 reads 0x55 before the edge.
- Reset priority: rst=1, we=1, wa=1, wd=0xAA at the same posedge -> reg1 reads 0x00 and all other registers read 0x00.
- Overwrite: write reg7=0x12 then reg7=0x34 on consecutive edges -> rd2 with ra2=7 reads 0x34.
